// File: rtl/byte_packer.sv
// Byte-stream to 32-bit word assembler: the first byte lands in [31:24], and in_last
// flushes a partial word with PAD in the unused low lanes.
module byte_packer #(
    parameter logic [7:0] PAD = 8'h00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    input  logic        in_last,
    output logic        in_ready,
    output logic [31:0] out_word,
    output logic        out_valid,
    output logic [2:0]  out_bytes,
    input  logic        out_ready,
    output logic        busy
);

    localparam int unsigned BYTE_W  = 8;
    localparam int unsigned LANES   = 4;
    localparam int unsigned CNT_W   = 2;
    localparam int unsigned BYTES_W = 3;

    // Packed lanes: element LANES-1 is bits [31:24], so byte number k is element ~k.
    typedef logic [LANES-1:0][BYTE_W-1:0] lanes_t;

    logic [CNT_W-1:0] cnt;
    lanes_t           acc;
    lanes_t           merged;
    lanes_t           flushed;
    logic             accept;
    logic             complete;
    logic             take;

    // in_ready depends only on registered state and out_ready.
    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    assign complete = accept && ((cnt == CNT_W'(LANES - 1)) || in_last);
    assign take     = out_valid && out_ready;
    assign busy     = (cnt != '0);

    // Insert the incoming byte, then force every lane after it to PAD for an early flush.
    always_comb begin
        merged       = acc;
        merged[~cnt] = in_data;
        flushed      = merged;
        for (int k = 0; k < LANES; k++) begin
            if (CNT_W'(k) > cnt) begin
                flushed[~CNT_W'(k)] = PAD;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt       <= '0;
            acc       <= {LANES{PAD}};
            out_word  <= '0;
            out_bytes <= '0;
            out_valid <= 1'b0;
        end else if (complete) begin
            // A completion overwrites any word taken in the same cycle.
            out_word  <= flushed;
            out_bytes <= BYTES_W'(cnt) + BYTES_W'(1);
            out_valid <= 1'b1;
            cnt       <= '0;
            acc       <= {LANES{PAD}};
        end else begin
            if (accept) begin
                acc <= merged;
                cnt <= cnt + CNT_W'(1);
            end
            if (take) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: doc/byte_packer.md
# byte_packer

Byte-stream to 32-bit word assembler: the receive-side counterpart of the 32-bit-to-four-byte splitter. Accepts one byte per cycle over a valid/ready handshake and packs four bytes, first byte in the most significant lane, into a registered 32-bit word. The word is offered on a valid/ready output port. An `in_last` marker flushes a partial word early, with pad bytes. Sits between any byte-wide source (UART receive path, byte bus) and word-wide datapath logic.

## Interface
- `PAD`, default 8'h00: fill value for unused low lanes when a partial word is flushed.
- `clk`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high; clears all state on the rising edge where it is sampled high.
- `in_data`  in  8  incoming byte.
- `in_valid`  in  1  `in_data`/`in_last` are valid this cycle.
- `in_last`  in  1  current byte ends a word; sampled only on accept.
- `in_ready`  out  1  packer can accept a byte this cycle.
- `out_word`  out  32  assembled word; first byte in [31:24], second in [23:16], third in [15:8], fourth in [7:0].
- `out_valid`  out  1  `out_word`/`out_bytes` hold a word not yet taken.
- `out_bytes`  out  3  count of real bytes in `out_word` (1..4); lanes beyond it hold `PAD`.
- `out_ready`  in  1  consumer takes the word this cycle.
- `busy`  out  1  a partial word is being collected (lane count ≠ 0).

## Operation
- State:
  - lane counter `cnt` (2 bits, 0..3);
  - accumulation register `acc` (32 bits);
  - output holding register (`out_word`, `out_bytes`, `out_valid`).
- `in_ready = !out_valid || out_ready`. This is combinational from registered state and `out_ready` only, never from `in_valid`/`in_last`.
- Accept = `in_valid && in_ready`. On accept, the byte goes to lane `cnt`, i.e. bits [31-8*cnt : 24-8*cnt].
- Accept with `cnt < 3` and `in_last == 0`:
  - `acc` lane updated; `cnt <= cnt+1`.
- Accept with `cnt == 3` or `in_last == 1` (completion):
  - `out_word <=` `acc` with the new byte inserted, and lanes above index `cnt` forced to `PAD`;
  - `out_bytes <= cnt+1`; `out_valid <= 1`;
  - `cnt <= 0`; `acc <=` all lanes `PAD`.
- `in_last` on the 4th byte behaves identically to a normal 4th byte (`out_bytes = 4`).
- Output handshake: when `out_valid && out_ready` and no completion occurs in that cycle, `out_valid <= 0`. `out_word`/`out_bytes` keep their last value; the bench must not check them while `out_valid = 0`.
- Completion in the same cycle as the output is taken: the new word replaces the old one and `out_valid` stays 1. No bubble, no loss.
- While `out_valid && !out_ready`:
  - `in_ready = 0`; partial accumulation also stalls;
  - `out_word`/`out_bytes` are held stable until taken.
- `in_valid` with `in_ready = 0`: no state change; the source must hold its byte.
- `busy = (cnt != 0)`.

## Timing
- Reset values: `cnt = 0`, `acc` = all `PAD`, `out_word = 0`, `out_bytes = 0`, `out_valid = 0`, `busy = 0`. `in_ready = 1` in the first cycle after reset.
- Reset mid-word discards the partial bytes. Reset while `out_valid = 1` drops the pending word. Reset overrides any simultaneous accept or take.
- Latency: `out_valid` rises on the clock edge that accepts the completing byte, so the word is visible in the following cycle.
- Throughput: 1 byte/cycle sustained with `out_ready` held high. A 4-byte word emerges every 4 cycles, back to back.
- Counter wrap: `cnt` goes 3 → 0 only through completion; it never wraps silently.
- No combinational path from `in_data` to any output.

## Test plan
- **Reset:** after reset, check `out_valid = 0`, `out_word = 0`, `out_bytes = 0`, `busy = 0`, `in_ready = 1`.
- **Single word:** bytes CC, C0, 30, 03 on consecutive cycles, `out_ready = 1` → one cycle after the 4th byte, `out_word = 32'hCCC03003`, `out_bytes = 4`, `out_valid = 1` for exactly one cycle. This is the round-trip inverse of splitting 32'b11001100110000000011000000000011.
- **Early flush:** bytes AA, BB with `in_last` on BB, `PAD = 00` → `out_word = 32'hAABB0000`, `out_bytes = 2`, `cnt` back to 0.
- **Back-pressure:** `out_ready = 0` after word 11223344 completes.
  - Check `in_ready = 0`, `out_word` stable for 5 cycles, and a held input byte 55 is not consumed.
  - Raise `out_ready`: 55 is accepted that cycle; the next word starts with 55 in [31:24].
- **Streaming:** 12 bytes 01..0C with `out_ready = 1`, `in_valid` continuous → words 01020304, 05060708, 090A0B0C, each `out_bytes = 4`, no gaps, no drops.
- **Reset mid-word:** bytes DE, AD, then `reset` for 1 cycle, then 4 bytes 10, 20, 30, 40 → only one word, 10203040, is produced.
